csb_stub_term: RTL and testbench
================================

# csb_stub_term

Parametrised terminator for CSB slave ports of NVDLA sub-units compiled out of a small configuration such as nv_small_512_32_8_int8. Instead of tying the port to ground, it accepts every request so the CSB master never hangs. It returns a fixed read pattern after a configurable latency and acknowledges non-posted writes. Illegal accesses are flagged through a sticky interrupt and optional per-channel counters, so firmware touching an absent unit is detected instead of silently deadlocking.

## Interface
Parameters:
- NUM_CH, 2: number of terminated CSB ports, 1..8.
- RESP_LAT, 1: request-accept to response-pulse latency in cycles, 1..4.
- RD_PATTERN, 32'hDEAD_0000: read data returned; low 16 bits replaced by the request address.
- CNT_W, 16: access counter width.

Ports:
- nvdla_core_clk  in  1  core clock; all logic rising-edge.
- nvdla_core_rst  in  1  reset, asynchronous assert, active-high; synchronous release is the integrator's job.
- csb_req_valid  in  NUM_CH  per-channel request valid.
- csb_req_ready  out  NUM_CH  per-channel request ready.
- csb_req_addr  in  NUM_CH*16  request word address, channel i at [16i+15:16i].
- csb_req_wdat  in  NUM_CH*32  write data; ignored.
- csb_req_write  in  NUM_CH  1 = write, 0 = read.
- csb_req_nposted  in  NUM_CH  1 = write needs completion.
- csb_rsp_valid  out  NUM_CH  one-cycle response pulse.
- csb_rsp_is_wr  out  NUM_CH  1 = write completion, 0 = read data.
- csb_rsp_rdat  out  NUM_CH*32  read data, qualified by rsp_valid and !rsp_is_wr; 0 otherwise.
- stub_irq  out  1  sticky level: some channel was accessed.
- stub_irq_clr  in  1  clears stub_irq and hit flags.
- stub_hit  out  NUM_CH  sticky per-channel accessed flags.
- stub_cnt  out  NUM_CH*CNT_W  per-channel access counters (only with CSB_STUB_CNT_EN).
- stub_cnt_clr  in  1  clears all counters.

## Operation
- csb_req_ready is constant 1 out of reset. The pipeline is fully pipelined, so one request per channel per cycle is accepted.
- Accept is req_valid & req_ready. Each accepted read or non-posted write enters a per-channel RESP_LAT-deep shift pipeline. The pipeline carries valid, is_wr, and addr.
- Posted writes (write=1, nposted=0) produce no response. They still count, set the hit flag, and raise the IRQ.
- Read response: rdat = {RD_PATTERN[31:16], addr}.
- stub_hit[i] sets on any accept on channel i. stub_irq = |stub_hit.
- When stub_irq_clr and a new accept occur in the same cycle, set wins and the flag stays 1.
- Counters increment by 1 per accept and saturate at 2^CNT_W-1 with no wrap.
- When stub_cnt_clr and an accept occur in the same cycle, the counter loads 1.
- Channels are independent; there is no arbitration.

## Timing
- Reset values: req_ready=0 during reset and 1 from the first cycle after release. rsp_valid=0, rsp_is_wr=0, rsp_rdat=0, stub_hit=0, stub_irq=0, stub_cnt=0.
- Response latency: accept at edge N gives rsp_valid high for exactly the cycle after edge N+RESP_LAT-1. RESP_LAT=1 means a registered response one cycle after accept.
- Back-to-back accepts give back-to-back response pulses in order.
- stub_hit, stub_irq, and stub_cnt update one cycle after the accept.
- Reset asserted mid-pipeline flushes all in-flight responses; none are emitted after release.

## Configuration
- CSB_STUB_CNT_EN defined: per-channel saturating counters and stub_cnt_clr are present.
- CSB_STUB_CNT_EN undefined: counters are removed, stub_cnt is driven 0, and stub_cnt_clr is ignored. All other behaviour is identical.

## Structure
- Shared package nv_csb_stub_pkg holds:
  - CSB_ADDR_W=16 and CSB_DATA_W=32.
  - The RD_PATTERN default.
  - A packed struct for a pipeline entry {valid, is_wr, addr}.
- Sub-module csb_stub_ch covers one channel: response pipeline, hit flag, and counter. The top instantiates NUM_CH copies via generate and ORs the hit flags into stub_irq.

## Test plan
- Reset release, RESP_LAT=1: req_ready=1 next cycle; all outputs 0.
- Read on ch0, addr 16'h1234, RESP_LAT=3 -> single rsp_valid pulse 3 cycles later, rsp_is_wr=0, rdat=32'hDEAD1234; stub_hit=2'b01 and stub_irq=1.
- Non-posted write on ch1 -> rsp_valid with rsp_is_wr=1 after RESP_LAT. Posted write on ch1 -> no pulse, counter still +1.
- 5 back-to-back reads on ch0 and ch1 simultaneously -> 5 ordered pulses per channel, both counters = 5.
- CNT_W=4, 20 accesses -> counter holds 15. stub_cnt_clr in the same cycle as an accept -> counter = 1. irq_clr with a concurrent accept -> stub_irq stays 1.
- Assert reset with 2 responses in flight -> no rsp_valid after release; counters and flags 0.

Source files
------------

// File: rtl/nv_csb_stub_pkg.sv
// Shared types and constants for the CSB stub terminator.
// Pipeline entry layout, bus widths and the default read pattern.
package nv_csb_stub_pkg;

    localparam int CSB_ADDR_W = 16;
    localparam int CSB_DATA_W = 32;
    localparam logic [CSB_DATA_W-1:0] CSB_RD_PATTERN_DEF = 32'hDEAD_0000;

    typedef struct packed {
        logic                  valid;
        logic                  is_wr;
        logic [CSB_ADDR_W-1:0] addr;
    } csb_pipe_entry_t;

    // Read data carries the pattern in the upper half and echoes the word address below it.
    function automatic logic [CSB_DATA_W-1:0] csb_rd_data(
        input logic [CSB_DATA_W-1:0] pattern,
        input logic [CSB_ADDR_W-1:0] addr
    );
        return {pattern[CSB_DATA_W-1:CSB_ADDR_W], addr};
    endfunction

endpackage

// File: rtl/csb_stub_term_if.sv
// Bundled CSB request/response signals for NUM_CH terminated slave ports.
// The master modport is the CSB requester, the slave modport is the terminator.
interface csb_stub_term_if
    import nv_csb_stub_pkg::*;
#(
    parameter int NUM_CH = 2
);

    logic [NUM_CH-1:0]            csb_req_valid;
    logic [NUM_CH-1:0]            csb_req_ready;
    logic [NUM_CH*CSB_ADDR_W-1:0] csb_req_addr;
    logic [NUM_CH*CSB_DATA_W-1:0] csb_req_wdat;
    logic [NUM_CH-1:0]            csb_req_write;
    logic [NUM_CH-1:0]            csb_req_nposted;
    logic [NUM_CH-1:0]            csb_rsp_valid;
    logic [NUM_CH-1:0]            csb_rsp_is_wr;
    logic [NUM_CH*CSB_DATA_W-1:0] csb_rsp_rdat;

    modport master (
        output csb_req_valid, csb_req_addr, csb_req_wdat, csb_req_write, csb_req_nposted,
        input  csb_req_ready, csb_rsp_valid, csb_rsp_is_wr, csb_rsp_rdat
    );

    modport slave (
        input  csb_req_valid, csb_req_addr, csb_req_wdat, csb_req_write, csb_req_nposted,
        output csb_req_ready, csb_rsp_valid, csb_rsp_is_wr, csb_rsp_rdat
    );

endinterface

// File: rtl/csb_stub_term_ch.sv
// One terminated CSB channel: response shift pipeline, sticky hit flag and,
// when CSB_STUB_CNT_EN is defined, a saturating access counter.
module csb_stub_ch
    import nv_csb_stub_pkg::*;
#(
    parameter int                    RESP_LAT   = 1,
    parameter logic [CSB_DATA_W-1:0] RD_PATTERN = CSB_RD_PATTERN_DEF,
    parameter int                    CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_ready,
    input  logic                  req_valid,
    input  logic [CSB_ADDR_W-1:0] req_addr,
    input  logic                  req_write,
    input  logic                  req_nposted,
    output logic                  rsp_valid,
    output logic                  rsp_is_wr,
    output logic [CSB_DATA_W-1:0] rsp_rdat,
    input  logic                  irq_clr,
    output logic                  hit,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      cnt
);

    logic                             accept_s;
    csb_pipe_entry_t                  entry_s;
    csb_pipe_entry_t [RESP_LAT-1:0]   pipe_r;
    logic                             hit_r;

    assign accept_s = req_valid & req_ready;

    // Build the pipeline entry; posted writes never get a response slot.
    always_comb begin
        entry_s = '0;
        if (accept_s && (!req_write || req_nposted)) begin
            entry_s.valid = 1'b1;
            entry_s.is_wr = req_write;
            entry_s.addr  = req_addr;
        end else begin
            entry_s = '0;
        end
    end

    // Fixed-latency shift pipeline; the last stage is the response pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_r <= '0;
        end else begin
            pipe_r[0] <= entry_s;
            for (int k = 1; k < RESP_LAT; k++) begin
                pipe_r[k] <= pipe_r[k-1];
            end
        end
    end

    assign rsp_valid = pipe_r[RESP_LAT-1].valid;
    assign rsp_is_wr = pipe_r[RESP_LAT-1].valid & pipe_r[RESP_LAT-1].is_wr;
    assign rsp_rdat  = (pipe_r[RESP_LAT-1].valid && !pipe_r[RESP_LAT-1].is_wr)
                     ? csb_rd_data(RD_PATTERN, pipe_r[RESP_LAT-1].addr)
                     : {CSB_DATA_W{1'b0}};

    // Sticky hit flag; a new access outranks a concurrent clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_r <= 1'b0;
        end else if (accept_s) begin
            hit_r <= 1'b1;
        end else if (irq_clr) begin
            hit_r <= 1'b0;
        end else begin
            hit_r <= hit_r;
        end
    end

    assign hit = hit_r;

`ifdef CSB_STUB_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [CNT_W-1:0] cnt_r;

    // Saturating access counter; clear with a concurrent access restarts at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            cnt_r <= accept_s ? CNT_ONE : {CNT_W{1'b0}};
        end else if (accept_s && !(&cnt_r)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
`else
    logic unused_cnt_clr_s;

    assign unused_cnt_clr_s = cnt_clr;
    assign cnt              = {CNT_W{1'b0}};
`endif

endmodule

// File: rtl/csb_stub_term.sv
// CSB terminator for compiled-out NVDLA sub-units; answers every request on NUM_CH ports.
// Optional per-channel access counters are enabled with the CSB_STUB_CNT_EN macro.
module csb_stub_term
    import nv_csb_stub_pkg::*;
#(
    parameter int                    NUM_CH     = 2,
    parameter int                    RESP_LAT   = 1,
    parameter logic [CSB_DATA_W-1:0] RD_PATTERN = CSB_RD_PATTERN_DEF,
    parameter int                    CNT_W      = 16
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    csb_stub_term_if.slave          csb,
    output logic                    stub_irq,
    input  logic                    stub_irq_clr,
    output logic [NUM_CH-1:0]       stub_hit,
    output logic [NUM_CH*CNT_W-1:0] stub_cnt,
    input  logic                    stub_cnt_clr
);

    logic                            ready_r;
    logic [NUM_CH-1:0]               rsp_valid_s;
    logic [NUM_CH-1:0]               rsp_is_wr_s;
    logic [NUM_CH*CSB_DATA_W-1:0]    rsp_rdat_s;
    logic [NUM_CH-1:0]               hit_s;
    logic [NUM_CH*CNT_W-1:0]         cnt_s;
    logic                            unused_wdat_s;

    // Ready is held low in reset and is permanently high afterwards.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        csb_stub_ch #(
            .RESP_LAT   (RESP_LAT),
            .RD_PATTERN (RD_PATTERN),
            .CNT_W      (CNT_W)
        ) u_ch (
            .clk         (nvdla_core_clk),
            .rst         (nvdla_core_rst),
            .req_ready   (ready_r),
            .req_valid   (csb.csb_req_valid[i]),
            .req_addr    (csb.csb_req_addr[CSB_ADDR_W*i +: CSB_ADDR_W]),
            .req_write   (csb.csb_req_write[i]),
            .req_nposted (csb.csb_req_nposted[i]),
            .rsp_valid   (rsp_valid_s[i]),
            .rsp_is_wr   (rsp_is_wr_s[i]),
            .rsp_rdat    (rsp_rdat_s[CSB_DATA_W*i +: CSB_DATA_W]),
            .irq_clr     (stub_irq_clr),
            .hit         (hit_s[i]),
            .cnt_clr     (stub_cnt_clr),
            .cnt         (cnt_s[CNT_W*i +: CNT_W])
        );
    end

    // Write data is accepted and discarded.
    assign unused_wdat_s = ^csb.csb_req_wdat;

    assign csb.csb_req_ready = {NUM_CH{ready_r}};
    assign csb.csb_rsp_valid = rsp_valid_s;
    assign csb.csb_rsp_is_wr = rsp_is_wr_s;
    assign csb.csb_rsp_rdat  = rsp_rdat_s;
    assign stub_hit          = hit_s;
    assign stub_irq          = |hit_s;
    assign stub_cnt          = cnt_s;

endmodule

// File: tb/tb_csb_stub_term.sv
// Self-checking bench for csb_stub_term (NUM_CH=2, RESP_LAT=3, CNT_W=4) with a
// response scoreboard; counter expectations follow the CSB_STUB_CNT_EN setting.
module tb_csb_stub_term;

    localparam int NCH = 2;
    localparam int LAT = 3;
    localparam int CW  = 4;

`ifdef CSB_STUB_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        int          due;
        logic        is_wr;
        logic [31:0] rdat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stub_irq;
    logic              stub_irq_clr = 1'b0;
    logic [NCH-1:0]    stub_hit;
    logic [NCH*CW-1:0] stub_cnt;
    logic              stub_cnt_clr = 1'b0;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   pulses [NCH];
    exp_t sb_q0 [$];
    exp_t sb_q1 [$];
    logic [CW-1:0] m_cnt [NCH];
    logic          m_hit [NCH];

    csb_stub_term_if #(.NUM_CH(NCH)) csb_bus ();

    csb_stub_term #(
        .NUM_CH     (NCH),
        .RESP_LAT   (LAT),
        .RD_PATTERN (32'hDEAD_0000),
        .CNT_W      (CW)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .csb            (csb_bus),
        .stub_irq       (stub_irq),
        .stub_irq_clr   (stub_irq_clr),
        .stub_hit       (stub_hit),
        .stub_cnt       (stub_cnt),
        .stub_cnt_clr   (stub_cnt_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NCH*CW-1:0] exp_cnt();
        return CNT_EN ? {m_cnt[1], m_cnt[0]} : {(NCH*CW){1'b0}};
    endfunction

    function automatic logic [NCH-1:0] exp_hit();
        return {m_hit[1], m_hit[0]};
    endfunction

    // Response monitor: pop the scoreboard on every pulse and check time and payload.
    always @(negedge clk) begin
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            if (csb_bus.csb_rsp_valid[c]) begin
                pulses[c]++;
                if ((c == 0 && sb_q0.size() == 0) || (c == 1 && sb_q1.size() == 0)) begin
                    $display("FAIL unexpected_rsp ch%0d at cycle %0d: got a pulse, expected none", c, cyc);
                end else begin
                    if (c == 0) e = sb_q0.pop_front();
                    else        e = sb_q1.pop_front();
                    if (cyc !== e.due) $display("FAIL rsp_time ch%0d: got cycle %0d, expected %0d", c, cyc, e.due);
                    else n_pass++;
                    n_chk++;
                    if (csb_bus.csb_rsp_is_wr[c] !== e.is_wr) $display("FAIL rsp_is_wr ch%0d: got %b, expected %b", c, csb_bus.csb_rsp_is_wr[c], e.is_wr);
                    else n_pass++;
                    n_chk++;
                    if (csb_bus.csb_rsp_rdat[32*c +: 32] !== e.rdat) $display("FAIL rsp_rdat ch%0d: got %h, expected %h", c, csb_bus.csb_rsp_rdat[32*c +: 32], e.rdat);
                    else n_pass++;
                    n_chk++;
                end
            end else begin
                if (csb_bus.csb_rsp_rdat[32*c +: 32] !== 32'h0 || csb_bus.csb_rsp_is_wr[c] !== 1'b0)
                    $display("FAIL rsp_idle ch%0d: got rdat %h is_wr %b, expected 0", c, csb_bus.csb_rsp_rdat[32*c +: 32], csb_bus.csb_rsp_is_wr[c]);
                else n_pass++;
                n_chk++;
            end
        end
    end

    task automatic issue(input int c, input bit wr, input bit np, input logic [15:0] a);
        exp_t e;
        csb_bus.csb_req_valid[c]         = 1'b1;
        csb_bus.csb_req_write[c]         = wr;
        csb_bus.csb_req_nposted[c]       = np;
        csb_bus.csb_req_addr[16*c +: 16] = a;
        csb_bus.csb_req_wdat[32*c +: 32] = $urandom;
        if (!wr || np) begin
            e.due   = cyc + LAT;
            e.is_wr = wr;
            e.rdat  = wr ? 32'h0 : {16'hDEAD, a};
            if (c == 0) sb_q0.push_back(e);
            else        sb_q1.push_back(e);
        end
    endtask

    task automatic step();
        for (int c = 0; c < NCH; c++) begin
            if (stub_cnt_clr) m_cnt[c] = csb_bus.csb_req_valid[c] ? 4'd1 : 4'd0;
            else if (csb_bus.csb_req_valid[c] && m_cnt[c] != 4'hF) m_cnt[c] = m_cnt[c] + 4'd1;
            if (csb_bus.csb_req_valid[c]) m_hit[c] = 1'b1;
            else if (stub_irq_clr) m_hit[c] = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        csb_bus.csb_req_valid = '0;
        stub_irq_clr = 1'b0;
        stub_cnt_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        if (csb_bus.csb_req_ready !== 2'b00) $display("FAIL rst_ready: got %b, expected 00", csb_bus.csb_req_ready); else n_pass++;
        n_chk++;
        if (csb_bus.csb_rsp_valid !== 2'b00) $display("FAIL rst_rsp_valid: got %b, expected 00", csb_bus.csb_rsp_valid); else n_pass++;
        n_chk++;
        if (stub_hit !== 2'b00 || stub_irq !== 1'b0) $display("FAIL rst_flags: got hit %b irq %b, expected 00 0", stub_hit, stub_irq); else n_pass++;
        n_chk++;
        if (stub_cnt !== 8'h00) $display("FAIL rst_cnt: got %h, expected 00", stub_cnt); else n_pass++;
        n_chk++;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (csb_bus.csb_req_ready !== 2'b11) $display("FAIL rel_ready: got %b, expected 11", csb_bus.csb_req_ready); else n_pass++;
        n_chk++;
    endtask

    task automatic test_read();
        int p0 = pulses[0];
        issue(0, 1'b0, 1'b0, 16'h1234);
        step();
        if (stub_hit !== 2'b01 || stub_irq !== 1'b1) $display("FAIL read_flags: got hit %b irq %b, expected 01 1", stub_hit, stub_irq); else n_pass++;
        n_chk++;
        if (stub_cnt !== exp_cnt()) $display("FAIL read_cnt: got %h, expected %h", stub_cnt, exp_cnt()); else n_pass++;
        n_chk++;
        idle(LAT + 1);
        if (pulses[0] - p0 !== 1) $display("FAIL read_pulses: got %0d, expected 1", pulses[0] - p0); else n_pass++;
        n_chk++;
    endtask

    task automatic test_write();
        int p1;
        stub_irq_clr = 1'b1;
        step();
        if (stub_hit !== 2'b00 || stub_irq !== 1'b0) $display("FAIL irq_clr: got hit %b irq %b, expected 00 0", stub_hit, stub_irq); else n_pass++;
        n_chk++;
        p1 = pulses[1];
        issue(1, 1'b1, 1'b1, 16'h0042);
        step();
        idle(LAT + 1);
        if (pulses[1] - p1 !== 1) $display("FAIL np_write_pulses: got %0d, expected 1", pulses[1] - p1); else n_pass++;
        n_chk++;
        issue(1, 1'b1, 1'b0, 16'h0043);
        step();
        if (stub_hit !== 2'b10 || stub_irq !== 1'b1) $display("FAIL posted_flags: got hit %b irq %b, expected 10 1", stub_hit, stub_irq); else n_pass++;
        n_chk++;
        idle(LAT + 1);
        if (pulses[1] - p1 !== 1) $display("FAIL posted_pulses: got %0d, expected 1", pulses[1] - p1); else n_pass++;
        n_chk++;
        if (stub_cnt !== exp_cnt()) $display("FAIL write_cnt: got %h, expected %h", stub_cnt, exp_cnt()); else n_pass++;
        n_chk++;
    endtask

    task automatic test_back_to_back();
        int p0, p1;
        stub_cnt_clr = 1'b1;
        stub_irq_clr = 1'b1;
        step();
        p0 = pulses[0];
        p1 = pulses[1];
        for (int i = 0; i < 5; i++) begin
            issue(0, 1'b0, 1'b0, 16'hA000 + 16'(i));
            issue(1, 1'b0, 1'b0, 16'hB000 + 16'(i));
            step();
        end
        idle(LAT + 1);
        if (pulses[0] - p0 !== 5 || pulses[1] - p1 !== 5) $display("FAIL b2b_pulses: got %0d/%0d, expected 5/5", pulses[0] - p0, pulses[1] - p1); else n_pass++;
        n_chk++;
        if (stub_cnt !== exp_cnt()) $display("FAIL b2b_cnt: got %h, expected %h", stub_cnt, exp_cnt()); else n_pass++;
        n_chk++;
    endtask

    task automatic test_saturation();
        stub_cnt_clr = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            issue(0, 1'b1, 1'b0, 16'(i));
            step();
        end
        if (stub_cnt !== exp_cnt()) $display("FAIL sat_cnt: got %h, expected %h", stub_cnt, exp_cnt()); else n_pass++;
        n_chk++;
        stub_cnt_clr = 1'b1;
        issue(0, 1'b0, 1'b0, 16'h5555);
        step();
        if (stub_cnt !== exp_cnt()) $display("FAIL clr_accept_cnt: got %h, expected %h", stub_cnt, exp_cnt()); else n_pass++;
        n_chk++;
        stub_irq_clr = 1'b1;
        issue(1, 1'b1, 1'b0, 16'h0001);
        step();
        if (stub_irq !== 1'b1 || stub_hit !== exp_hit()) $display("FAIL clr_accept_irq: got hit %b irq %b, expected %b 1", stub_hit, stub_irq, exp_hit()); else n_pass++;
        n_chk++;
        idle(LAT + 1);
    endtask

    task automatic test_reset_flush();
        int p0, p1;
        issue(0, 1'b0, 1'b0, 16'h0001);
        issue(1, 1'b1, 1'b1, 16'h0002);
        step();
        issue(0, 1'b0, 1'b0, 16'h0003);
        step();
        rst = 1'b1;
        sb_q0.delete();
        sb_q1.delete();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 4'd0;
            m_hit[c] = 1'b0;
        end
        p0 = pulses[0];
        p1 = pulses[1];
        @(negedge clk);
        if (csb_bus.csb_req_ready !== 2'b00 || csb_bus.csb_rsp_valid !== 2'b00) $display("FAIL flush_in_rst: got ready %b rsp %b, expected 00 00", csb_bus.csb_req_ready, csb_bus.csb_rsp_valid); else n_pass++;
        n_chk++;
        rst = 1'b0;
        idle(LAT + 3);
        if (pulses[0] - p0 !== 0 || pulses[1] - p1 !== 0) $display("FAIL flush_pulses: got %0d/%0d, expected 0/0", pulses[0] - p0, pulses[1] - p1); else n_pass++;
        n_chk++;
        if (stub_hit !== 2'b00 || stub_irq !== 1'b0 || stub_cnt !== 8'h00) $display("FAIL flush_state: got hit %b irq %b cnt %h, expected 00 0 00", stub_hit, stub_irq, stub_cnt); else n_pass++;
        n_chk++;
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            pulses[c] = 0;
            m_cnt[c]  = 4'd0;
            m_hit[c]  = 1'b0;
        end
        csb_bus.csb_req_valid   = '0;
        csb_bus.csb_req_write   = '0;
        csb_bus.csb_req_nposted = '0;
        csb_bus.csb_req_addr    = '0;
        csb_bus.csb_req_wdat    = '0;

        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_saturation();
        test_reset_flush();

        if (sb_q0.size() != 0 || sb_q1.size() != 0) $display("FAIL drain: got %0d/%0d pending, expected 0/0", sb_q0.size(), sb_q1.size()); else n_pass++;
        n_chk++;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
